timer_seq: RTL and testbench
============================

Name: timer_seq

Overview:
- Sequencer that drives the timer's register-write and start interface from a small table of timer settings.
- Each table entry holds a period, a duty and a repeat count.
- On a go command the block programs the timer with one entry, pulses the timer's start input, waits for the timer to report its end, then moves to the next entry.
- The block sits between a host configuration bus and the timer.

Parameters:
- DW, 16, width of the timer data word and of each table field.
- DEPTH, 4, number of table entries; must be a power of two.
- IW, 2, entry index width, equal to log2(DEPTH).

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cfg_we  in  1  host write strobe for the table or the control register.
- i_cfg_idx  in  IW  table entry to write.
- i_cfg_field  in  2  field select: 0 period, 1 duty, 2 repeat, 3 control.
- i_cfg_wdata  in  DW  host write data.
- i_go  in  1  single-cycle command that starts the sequence.
- i_stop  in  1  single-cycle command that aborts the sequence.
- o_tmr_we  out  1  timer register write enable.
- o_tmr_addr  out  2  timer register address: 0 period, 1 duty, 2 repeat.
- o_tmr_wdata  out  DW  timer register write data.
- o_tmr_start  out  1  one-cycle start pulse to the timer.
- i_tmr_end  in  1  end indication from the timer.
- o_busy  out  1  high in every state except IDLE.
- o_step  out  IW  index of the entry currently being run.
- o_done  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Reset:
  - All outputs are 0.
  - All table fields are 0.
  - Control register is 0.
  - State is IDLE and the step counter is 0.
- Control register (field 3):
  - Bits [IW-1:0] give LAST, the index of the final entry.
  - Bit DW-1 is LOOP.
  - All other bits are ignored.
  - i_cfg_idx is ignored when field 3 is written.
- Configuration writes:
  - Accepted only in IDLE; the table updates on the clock edge where i_cfg_we is high.
  - While o_busy is high, writes are silently dropped.
- All outputs are registered (Moore outputs). Only one of o_tmr_we or o_tmr_start is high in any cycle.
- FSM states: IDLE, WR_PER, WR_DUTY, WR_REP, START, WAIT, NEXT.
- IDLE:
  - On i_go=1 and i_stop=0, clear the step counter to 0.
  - Go to WR_PER, or to NEXT if period[0] is 0.
  - The first write cycle is the cycle after i_go is sampled.
- Write states (each lasts exactly one cycle, o_tmr_we=1):
  - WR_PER: o_tmr_addr=0, o_tmr_wdata=period[step].
  - WR_DUTY: o_tmr_addr=1, o_tmr_wdata=duty[step].
  - WR_REP: o_tmr_addr=2, o_tmr_wdata=repeat[step].
- Outside the write states, o_tmr_addr and o_tmr_wdata are 0.
- START: o_tmr_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold until i_tmr_end=1 is sampled, then go to NEXT.
  - i_tmr_end is ignored in every other state.
- NEXT (one cycle):
  - If step is not LAST: increment step and go to WR_PER.
  - If step is LAST and LOOP=1: set step to 0 and go to WR_PER.
  - If step is LAST and LOOP=0: o_done=1 in the cycle after NEXT, and the state is IDLE in that cycle.
- Zero-period skip:
  - Before entering WR_PER, the FSM checks the period of the target entry.
  - If that period is 0, it goes straight to NEXT for that index, with no timer writes and no start pulse.
  - If every entry up to LAST has period 0, the sequence ends with o_done (LOOP=0), or spins through NEXT with o_busy=1 (LOOP=1) until i_stop.
- Per-step overhead: 5 cycles (3 writes, 1 start, 1 NEXT) plus the time spent in WAIT.
- i_stop:
  - In any non-IDLE state, the next state is IDLE.
  - All timer outputs drop in that cycle and no o_done is generated.
  - i_stop takes priority over i_go and i_tmr_end.
- i_go while busy is ignored.
- Asynchronous reset mid-sequence returns immediately to reset values.
- The step counter wraps naturally at DEPTH-1+1=0. LAST bounds the sequence.
- LAST and LOOP are sampled live (they cannot change while busy).

Test Plan:
1. Reset then idle: apply reset, release it, hold i_go low for 10 cycles -> all outputs 0 throughout, o_busy=0.
2. Single entry: entry 0 = {20, 10, 2}, LAST=0, LOOP=0, pulse i_go -> next three cycles show writes (addr 0, 20), (addr 1, 10), (addr 2, 2); then o_tmr_start for 1 cycle; o_busy held until i_tmr_end; o_done pulses exactly once 2 cycles after i_tmr_end.
3. Multi-step with skip: entries {20,10,2}, {0,5,1}, {8,4,3}, LAST=2, pulse i_go -> entry 0 programmed, then entry 2 programmed after the first i_tmr_end; o_step goes 0, 1, 2; entry 1 produces no o_tmr_we or o_tmr_start.
4. Loop plus stop: LAST=1, LOOP=1, drive i_tmr_end 3 times -> o_step sequence 0, 1, 0, 1 with no o_done; i_stop asserted in WAIT -> o_busy=0 next cycle, no further o_tmr_start.
5. Writes blocked while busy: during WAIT write period[0]=99 -> ignored; after completion, i_go reprograms period 20; then write 99 in IDLE, pulse i_go -> write data is 99.
6. Simultaneous and abort events: i_go together with i_stop in IDLE -> stays IDLE. i_tmr_end pulsed during WR_DUTY -> ignored, FSM still waits in WAIT. Reset asserted in WR_DUTY -> outputs 0 immediately, table cleared.

Source files
------------

// File: rtl/timer_seq.sv
// Timer sequencer: programs period/duty/repeat of one table entry into the timer, pulses start,
// waits for the timer's end indication, then advances to the next entry up to LAST.
module timer_seq #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cfg_we,
    input  logic [IW-1:0] i_cfg_idx,
    input  logic [1:0]    i_cfg_field,
    input  logic [DW-1:0] i_cfg_wdata,
    input  logic          i_go,
    input  logic          i_stop,
    output logic          o_tmr_we,
    output logic [1:0]    o_tmr_addr,
    output logic [DW-1:0] o_tmr_wdata,
    output logic          o_tmr_start,
    input  logic          i_tmr_end,
    output logic          o_busy,
    output logic [IW-1:0] o_step,
    output logic          o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StWrPer,
        StWrDuty,
        StWrRep,
        StStart,
        StWait,
        StNext
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] step_q, step_d;
    logic [IW-1:0] next_idx;
    logic          done_q, done_d;

    logic [DW-1:0] period_q [DEPTH];
    logic [DW-1:0] duty_q   [DEPTH];
    logic [DW-1:0] rep_q    [DEPTH];
    logic [IW-1:0] last_q;
    logic          loop_q;

    logic          tmr_we_q, tmr_we_d;
    logic [1:0]    tmr_addr_q, tmr_addr_d;
    logic [DW-1:0] tmr_wdata_q, tmr_wdata_d;
    logic          tmr_start_q, tmr_start_d;
    logic          busy_q;

    // Host configuration; the table is frozen while a sequence is running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                rep_q[i]    <= '0;
            end
            last_q <= '0;
            loop_q <= 1'b0;
        end else if (i_cfg_we && (state_q == StIdle)) begin
            unique case (i_cfg_field)
                2'd0: period_q[i_cfg_idx] <= i_cfg_wdata;
                2'd1: duty_q[i_cfg_idx]   <= i_cfg_wdata;
                2'd2: rep_q[i_cfg_idx]    <= i_cfg_wdata;
                2'd3: begin
                    last_q <= i_cfg_wdata[IW-1:0];
                    loop_q <= i_cfg_wdata[DW-1];
                end
                default: ;
            endcase
        end
    end

    // State register and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            step_q      <= '0;
            done_q      <= 1'b0;
            tmr_we_q    <= 1'b0;
            tmr_addr_q  <= '0;
            tmr_wdata_q <= '0;
            tmr_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            done_q      <= done_d;
            tmr_we_q    <= tmr_we_d;
            tmr_addr_q  <= tmr_addr_d;
            tmr_wdata_q <= tmr_wdata_d;
            tmr_start_q <= tmr_start_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    assign next_idx = (step_q == last_q) ? '0 : step_q + IW'(1);

    // Next-state logic; entries with a zero period are routed straight to StNext.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_go && !i_stop) begin
                    step_d  = '0;
                    state_d = (period_q[0] == '0) ? StNext : StWrPer;
                end
            end
            StWrPer:  state_d = StWrDuty;
            StWrDuty: state_d = StWrRep;
            StWrRep:  state_d = StStart;
            StStart:  state_d = StWait;
            StWait: begin
                if (i_tmr_end) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if ((step_q == last_q) && !loop_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    step_d  = next_idx;
                    state_d = (period_q[next_idx] == '0) ? StNext : StWrPer;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over every other event and suppresses completion.
        if (i_stop && (state_q != StIdle)) begin
            state_d = StIdle;
            step_d  = step_q;
            done_d  = 1'b0;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        tmr_we_d    = 1'b0;
        tmr_addr_d  = '0;
        tmr_wdata_d = '0;
        tmr_start_d = 1'b0;
        unique case (state_d)
            StWrPer: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd0;
                tmr_wdata_d = period_q[step_d];
            end
            StWrDuty: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd1;
                tmr_wdata_d = duty_q[step_d];
            end
            StWrRep: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd2;
                tmr_wdata_d = rep_q[step_d];
            end
            StStart: tmr_start_d = 1'b1;
            default: ;
        endcase
    end

    assign o_tmr_we    = tmr_we_q;
    assign o_tmr_addr  = tmr_addr_q;
    assign o_tmr_wdata = tmr_wdata_q;
    assign o_tmr_start = tmr_start_q;
    assign o_busy      = busy_q;
    assign o_step      = step_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_timer_seq.sv
// Self-checking bench for timer_seq: scoreboard of expected timer writes plus a table of
// single-entry runs and hand-written multi-cycle sequences.
module tb_timer_seq;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cfg_we = 1'b0;
    logic [IW-1:0] i_cfg_idx = '0;
    logic [1:0]    i_cfg_field = '0;
    logic [DW-1:0] i_cfg_wdata = '0;
    logic          i_go = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_tmr_end = 1'b0;
    logic          o_tmr_we;
    logic [1:0]    o_tmr_addr;
    logic [DW-1:0] o_tmr_wdata;
    logic          o_tmr_start;
    logic          o_busy;
    logic [IW-1:0] o_step;
    logic          o_done;

    always #5 i_clk = ~i_clk;

    timer_seq #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_idx   (i_cfg_idx),
        .i_cfg_field (i_cfg_field),
        .i_cfg_wdata (i_cfg_wdata),
        .i_go        (i_go),
        .i_stop      (i_stop),
        .o_tmr_we    (o_tmr_we),
        .o_tmr_addr  (o_tmr_addr),
        .o_tmr_wdata (o_tmr_wdata),
        .o_tmr_start (o_tmr_start),
        .i_tmr_end   (i_tmr_end),
        .o_busy      (o_busy),
        .o_step      (o_step),
        .o_done      (o_done)
    );

    typedef struct packed {
        logic [1:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [DW-1:0] p;
        logic [DW-1:0] d;
        logic [DW-1:0] r;
        int            exp_wr;
        int            exp_st;
    } vec_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [IW-1:0] start_steps[$];
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_tmr_we || o_tmr_start)
                check("we_start_exclusive", 32'(o_tmr_we & o_tmr_start), 32'd0);
            if (o_tmr_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected none",
                             o_tmr_addr, o_tmr_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tmr_write", {14'd0, o_tmr_addr, o_tmr_wdata},
                          {14'd0, mon_e.addr, mon_e.data});
                end
            end else if (o_busy) begin
                check("bus_zero_outside_writes", {14'd0, o_tmr_addr, o_tmr_wdata}, 32'd0);
            end
            if (o_tmr_start) begin
                start_cnt++;
                start_steps.push_back(o_step);
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] f, input logic [IW-1:0] idx, input logic [DW-1:0] d);
        i_cfg_we    = 1'b1;
        i_cfg_field = f;
        i_cfg_idx   = idx;
        i_cfg_wdata = d;
        tick();
        i_cfg_we    = 1'b0;
        i_cfg_field = '0;
        i_cfg_idx   = '0;
        i_cfg_wdata = '0;
    endtask

    task automatic set_entry(input logic [IW-1:0] idx, input logic [DW-1:0] p,
                             input logic [DW-1:0] d, input logic [DW-1:0] r);
        cfg(2'd0, idx, p);
        cfg(2'd1, idx, d);
        cfg(2'd2, idx, r);
    endtask

    task automatic set_ctrl(input logic [IW-1:0] last, input logic loop);
        logic [DW-1:0] w;
        w          = '0;
        w[DW-1]    = loop;
        w[IW-1:0]  = last;
        w[IW+2]    = 1'b1;  // ignored bit
        cfg(2'd3, 2'd3, w);
    endtask

    task automatic push_entry(input logic [DW-1:0] p, input logic [DW-1:0] d,
                              input logic [DW-1:0] r);
        exp_q.push_back(wr_t'{addr: 2'd0, data: p});
        exp_q.push_back(wr_t'{addr: 2'd1, data: d});
        exp_q.push_back(wr_t'{addr: 2'd2, data: r});
    endtask

    task automatic pulse_go();
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
    endtask

    task automatic pulse_end();
        i_tmr_end = 1'b1;
        tick();
        i_tmr_end = 1'b0;
    endtask

    // Returns with the DUT in WAIT (one cycle after the start pulse).
    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (o_tmr_start) seen = 1'b1;
            else tick();
        end
        check({name, "_start_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (o_done) seen = 1'b1;
            else tick();
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int w0, s0, d0;

        vecs[0] = '{p: 16'd20,     d: 16'd10, r: 16'd2,      exp_wr: 3, exp_st: 1};
        vecs[1] = '{p: 16'd0,      d: 16'd5,  r: 16'd1,      exp_wr: 0, exp_st: 0};
        vecs[2] = '{p: 16'hFFFF,   d: 16'd0,  r: 16'h8000,   exp_wr: 3, exp_st: 1};
        vecs[3] = '{p: 16'd1,      d: 16'd1,  r: 16'd1,      exp_wr: 3, exp_st: 1};

        // Reset then idle
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_idle_outputs",
                  {8'd0, o_tmr_we, o_tmr_addr, o_tmr_wdata, o_tmr_start, o_busy, o_step, o_done},
                  32'd0);
        end

        // Single entry with exact cycle timing
        set_entry(2'd0, 16'd20, 16'd10, 16'd2);
        set_ctrl(2'd0, 1'b0);
        push_entry(16'd20, 16'd10, 16'd2);
        d0 = done_cnt;
        pulse_go();
        check("t2_wr_per", {o_tmr_we, o_tmr_addr, o_tmr_wdata}, {1'b1, 2'd0, 16'd20});
        tick();
        check("t2_wr_duty", {o_tmr_we, o_tmr_addr, o_tmr_wdata}, {1'b1, 2'd1, 16'd10});
        tick();
        check("t2_wr_rep", {o_tmr_we, o_tmr_addr, o_tmr_wdata}, {1'b1, 2'd2, 16'd2});
        tick();
        check("t2_start", {o_tmr_start, o_tmr_we, o_busy}, 3'b101);
        tick();
        check("t2_wait", {o_tmr_start, o_busy}, 2'b01);
        repeat (5) tick();
        check("t2_wait_hold", {o_busy, o_done}, 2'b10);
        pulse_end();
        check("t2_next", {o_busy, o_done}, 2'b10);
        tick();
        check("t2_done", {o_busy, o_done}, 2'b01);
        tick();
        check("t2_done_pulse_end", 32'(o_done), 32'd0);
        check("t2_done_count", done_cnt - d0, 32'd1);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // Table-driven single-entry runs
        for (int i = 0; i < 4; i++) begin
            set_entry(2'd0, vecs[i].p, vecs[i].d, vecs[i].r);
            set_ctrl(2'd0, 1'b0);
            if (vecs[i].p != '0) push_entry(vecs[i].p, vecs[i].d, vecs[i].r);
            w0 = wr_cnt;
            s0 = start_cnt;
            d0 = done_cnt;
            pulse_go();
            if (vecs[i].exp_st != 0) begin
                wait_start("vec");
                pulse_end();
            end
            wait_done("vec");
            tick();
            check("vec_writes", wr_cnt - w0, vecs[i].exp_wr);
            check("vec_starts", start_cnt - s0, vecs[i].exp_st);
            check("vec_done", done_cnt - d0, 32'd1);
            check("vec_queue_empty", exp_q.size(), 32'd0);
        end

        // Multi-step with a zero-period entry skipped
        set_entry(2'd0, 16'd20, 16'd10, 16'd2);
        set_entry(2'd1, 16'd0, 16'd5, 16'd1);
        set_entry(2'd2, 16'd8, 16'd4, 16'd3);
        set_ctrl(2'd2, 1'b0);
        push_entry(16'd20, 16'd10, 16'd2);
        push_entry(16'd8, 16'd4, 16'd3);
        start_steps.delete();
        w0 = wr_cnt;
        s0 = start_cnt;
        d0 = done_cnt;
        pulse_go();
        wait_start("t3_e0");
        check("t3_step0", 32'(o_step), 32'd0);
        pulse_end();
        check("t3_next0", {o_step, o_tmr_we, o_busy}, {2'd0, 1'b0, 1'b1});
        tick();
        check("t3_skip1", {o_step, o_tmr_we, o_tmr_start}, {2'd1, 1'b0, 1'b0});
        tick();
        check("t3_wr_e2", {o_step, o_tmr_we, o_tmr_addr}, {2'd2, 1'b1, 2'd0});
        wait_start("t3_e2");
        pulse_end();
        wait_done("t3");
        tick();
        check("t3_writes", wr_cnt - w0, 32'd6);
        check("t3_starts", start_cnt - s0, 32'd2);
        check("t3_done", done_cnt - d0, 32'd1);
        check("t3_start_steps", {start_steps.size() == 2,
              (start_steps.size() == 2) ? {start_steps[0], start_steps[1]} : 4'hF},
              {1'b1, 2'd0, 2'd2});

        // Loop then stop in WAIT
        set_entry(2'd1, 16'd8, 16'd4, 16'd3);
        set_ctrl(2'd1, 1'b1);
        push_entry(16'd20, 16'd10, 16'd2);
        push_entry(16'd8, 16'd4, 16'd3);
        push_entry(16'd20, 16'd10, 16'd2);
        push_entry(16'd8, 16'd4, 16'd3);
        start_steps.delete();
        d0 = done_cnt;
        pulse_go();
        for (int k = 0; k < 3; k++) begin
            wait_start("t4_loop");
            pulse_end();
        end
        wait_start("t4_last");
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("t4_stop_idle", {o_busy, o_tmr_start, o_tmr_we}, 3'b000);
        s0 = start_cnt;
        repeat (10) tick();
        check("t4_no_more_starts", start_cnt - s0, 32'd0);
        check("t4_no_done", done_cnt - d0, 32'd0);
        check("t4_start_steps", {start_steps.size() == 4,
              (start_steps.size() == 4) ?
              {start_steps[0], start_steps[1], start_steps[2], start_steps[3]} : 8'hFF},
              {1'b1, 2'd0, 2'd1, 2'd0, 2'd1});
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // Config writes dropped while busy
        set_ctrl(2'd0, 1'b0);
        push_entry(16'd20, 16'd10, 16'd2);
        pulse_go();
        wait_start("t5_a");
        cfg(2'd0, 2'd0, 16'd99);
        pulse_end();
        wait_done("t5_a");
        tick();
        push_entry(16'd20, 16'd10, 16'd2);
        pulse_go();
        wait_start("t5_b");
        pulse_end();
        wait_done("t5_b");
        tick();
        cfg(2'd0, 2'd0, 16'd99);
        push_entry(16'd99, 16'd10, 16'd2);
        pulse_go();
        check("t5_new_period", {o_tmr_we, o_tmr_wdata}, {1'b1, 16'd99});
        wait_start("t5_c");
        pulse_end();
        wait_done("t5_c");
        tick();
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // go together with stop in IDLE
        w0 = wr_cnt;
        i_go = 1'b1;
        i_stop = 1'b1;
        tick();
        i_go = 1'b0;
        i_stop = 1'b0;
        check("t6_go_stop_idle", 32'(o_busy), 32'd0);
        tick();
        check("t6_go_stop_no_write", wr_cnt - w0, 32'd0);

        // tmr_end during WR_DUTY is ignored
        set_entry(2'd0, 16'd20, 16'd10, 16'd2);
        push_entry(16'd20, 16'd10, 16'd2);
        d0 = done_cnt;
        pulse_go();
        tick();
        check("t6_in_wr_duty", {o_tmr_we, o_tmr_addr}, {1'b1, 2'd1});
        pulse_end();
        wait_start("t6_end_early");
        repeat (3) tick();
        check("t6_still_waiting", {o_busy, o_step}, {1'b1, 2'd0});
        check("t6_no_early_done", done_cnt - d0, 32'd0);
        pulse_end();
        wait_done("t6_end");
        tick();

        // Asynchronous reset in WR_DUTY
        push_entry(16'd20, 16'd10, 16'd2);
        pulse_go();
        tick();
        check("t6_rst_in_wr_duty", {o_tmr_we, o_tmr_addr}, {1'b1, 2'd1});
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_outputs",
              {8'd0, o_tmr_we, o_tmr_addr, o_tmr_wdata, o_tmr_start, o_busy, o_step, o_done},
              32'd0);
        exp_q.delete();
        tick();
        i_rst_n = 1'b1;
        tick();
        w0 = wr_cnt;
        s0 = start_cnt;
        d0 = done_cnt;
        pulse_go();
        wait_done("t6_cleared");
        tick();
        check("t6_cleared_no_writes", wr_cnt - w0, 32'd0);
        check("t6_cleared_no_start", start_cnt - s0, 32'd0);
        check("t6_cleared_done", done_cnt - d0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
